// File: rtl/rtc_pkg.sv
// rtc_pkg: shared FSM state type, RTC scan address table and default bus timing.
package rtc_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_A_SETUP, ST_A_STROBE, ST_A_HOLD,
    ST_D_SETUP, ST_D_STROBE, ST_D_HOLD, ST_RECOVER
  } bus_state_t;
  localparam logic [7:0] RTC_ADDR_SEC   = 8'h21;
  localparam logic [7:0] RTC_ADDR_MIN   = 8'h22;
  localparam logic [7:0] RTC_ADDR_HOUR  = 8'h23;
  localparam logic [7:0] RTC_ADDR_DAY   = 8'h24;
  localparam logic [7:0] RTC_ADDR_MONTH = 8'h25;
  localparam logic [7:0] RTC_ADDR_YEAR  = 8'h26;
  localparam int T_SETUP_DEF     = 2;
  localparam int T_STROBE_DEF    = 4;
  localparam int T_HOLD_DEF      = 2;
  localparam int T_REC_DEF       = 4;
  localparam int SCAN_PERIOD_DEF = 1000000;
  localparam int NUM_SCAN_DEF    = 6;
  function automatic logic [7:0] scan_addr(input logic [2:0] idx);
    return idx == 3'd1 ? RTC_ADDR_MIN :
           idx == 3'd2 ? RTC_ADDR_HOUR :
           idx == 3'd3 ? RTC_ADDR_DAY :
           idx == 3'd4 ? RTC_ADDR_MONTH :
           idx == 3'd5 ? RTC_ADDR_YEAR : RTC_ADDR_SEC;
  endfunction
endpackage

// File: rtl/rtc_bus_cycle.sv
// rtc_bus_cycle: one multiplexed RTC bus transaction (address phase, data phase, recovery).
module rtc_bus_cycle
  import rtc_pkg::*;
#(
  parameter int T_SETUP  = T_SETUP_DEF,
  parameter int T_STROBE = T_STROBE_DEF,
  parameter int T_HOLD   = T_HOLD_DEF,
  parameter int T_REC    = T_REC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       is_write,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       aod,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);
  bus_state_t r_state, w_nxt;
  logic [7:0] r_cnt, r_addr, r_wdata, r_rdata, r_ad_out, w_addr, w_wdata;
  logic r_wr, r_cs_n, r_rd_n, r_wr_n, r_aod, r_ad_oe;
  logic w_last, w_take, w_wr, w_a, w_d;

  function automatic logic [7:0] dur(input bus_state_t s);
    return (s == ST_A_SETUP  || s == ST_D_SETUP)  ? 8'(T_SETUP - 1) :
           (s == ST_A_STROBE || s == ST_D_STROBE) ? 8'(T_STROBE - 1) :
           (s == ST_A_HOLD   || s == ST_D_HOLD)   ? 8'(T_HOLD - 1) :
           (s == ST_RECOVER) ? 8'(T_REC - 1) : 8'd0;
  endfunction

  always_comb begin
    w_last  = r_cnt == 8'd0;
    w_take  = r_state == ST_IDLE && start;
    w_nxt   = r_state == ST_IDLE ? (start ? ST_A_SETUP : ST_IDLE) :
              w_last ? bus_state_t'(r_state + 3'd1) : r_state;
    w_wr    = w_take ? is_write : r_wr;
    w_addr  = w_take ? addr : r_addr;
    w_wdata = w_take ? wdata : r_wdata;
    w_a     = w_nxt == ST_A_SETUP || w_nxt == ST_A_STROBE || w_nxt == ST_A_HOLD;
    w_d     = w_nxt == ST_D_SETUP || w_nxt == ST_D_STROBE || w_nxt == ST_D_HOLD;
  end

  // Pins are registered from the next state so they change exactly on phase boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      r_wr     <= 1'b0;
      r_addr   <= 8'd0;
      r_wdata  <= 8'd0;
      r_rdata  <= 8'd0;
      r_cs_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_aod    <= 1'b1;
      r_ad_oe  <= 1'b0;
      r_ad_out <= 8'd0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt != r_state) ? dur(w_nxt) : (w_last ? 8'd0 : r_cnt - 8'd1);
      if (w_take) begin
        r_wr    <= is_write;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      if (r_state == ST_D_STROBE && w_last && !r_wr) r_rdata <= ad_in;
      r_cs_n   <= !(w_a || w_d);
      r_rd_n   <= !(w_nxt == ST_D_STROBE && !w_wr);
      r_wr_n   <= !(w_nxt == ST_A_STROBE || (w_nxt == ST_D_STROBE && w_wr));
      r_aod    <= !w_a;
      r_ad_oe  <= w_a || (w_d && w_wr);
      r_ad_out <= w_a ? w_addr : (w_d && w_wr) ? w_wdata : 8'd0;
    end
  end

  assign done   = r_state == ST_RECOVER && w_last;
  assign busy   = r_state != ST_IDLE;
  assign rdata  = r_rdata;
  assign cs_n   = r_cs_n;
  assign rd_n   = r_rd_n;
  assign wr_n   = r_wr_n;
  assign aod    = r_aod;
  assign ad_out = r_ad_out;
  assign ad_oe  = r_ad_oe;
endmodule

// File: rtl/rtc_access_scheduler.sv
// rtc_access_scheduler: arbitrates user writes against periodic time readback sweeps
// on the RTC bus and publishes a coherent BCD time snapshot.
module rtc_access_scheduler
  import rtc_pkg::*;
#(
  parameter int T_SETUP     = T_SETUP_DEF,
  parameter int T_STROBE    = T_STROBE_DEF,
  parameter int T_HOLD      = T_HOLD_DEF,
  parameter int T_REC       = T_REC_DEF,
  parameter int SCAN_PERIOD = SCAN_PERIOD_DEF,
  parameter int NUM_SCAN    = NUM_SCAN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic       scan_en,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic [7:0] day,
  output logic [7:0] month,
  output logic [7:0] year,
  output logic       time_valid,
  output logic       scan_overrun,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       aod,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);
  localparam int PW = $clog2(SCAN_PERIOD);

  logic [PW-1:0] r_period;
  logic [2:0] r_idx;
  logic [7:0] r_shadow [NUM_SCAN-1];
  logic [7:0] r_sec, r_min, r_hour, r_day, r_month, r_year, w_rdata, w_addr;
  logic r_pending, r_active, r_cur_wr, r_time_valid, r_overrun;
  logic w_busy, w_done, w_trig, w_start_wr, w_start_scan, w_start, w_scan_done, w_last_idx;

  always_comb begin
    w_trig       = scan_en && r_period == PW'(SCAN_PERIOD - 1);
    w_start_wr   = !w_busy && wr_req;
    w_start_scan = !w_busy && !wr_req && (r_active || r_pending);
    w_start      = w_start_wr || w_start_scan;
    w_addr       = w_start_wr ? wr_addr : scan_addr(r_idx);
    w_scan_done  = w_done && !r_cur_wr;
    w_last_idx   = r_idx == 3'(NUM_SCAN - 1);
  end

  rtc_bus_cycle #(
    .T_SETUP (T_SETUP),
    .T_STROBE(T_STROBE),
    .T_HOLD  (T_HOLD),
    .T_REC   (T_REC)
  ) u_bus (
    .clk     (clk),
    .reset   (reset),
    .start   (w_start),
    .is_write(w_start_wr),
    .addr    (w_addr),
    .wdata   (wr_data),
    .done    (w_done),
    .rdata   (w_rdata),
    .busy    (w_busy),
    .cs_n    (cs_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .aod     (aod),
    .ad_out  (ad_out),
    .ad_oe   (ad_oe),
    .ad_in   (ad_in)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_period     <= '0;
      r_idx        <= 3'd0;
      r_pending    <= 1'b0;
      r_active     <= 1'b0;
      r_cur_wr     <= 1'b0;
      r_time_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_sec        <= 8'd0;
      r_min        <= 8'd0;
      r_hour       <= 8'd0;
      r_day        <= 8'd0;
      r_month      <= 8'd0;
      r_year       <= 8'd0;
      for (int i = 0; i < NUM_SCAN - 1; i++) r_shadow[i] <= 8'd0;
    end else begin
      r_period     <= (!scan_en || w_trig) ? '0 : r_period + PW'(1);
      r_overrun    <= w_trig && (r_pending || r_active);
      r_time_valid <= w_scan_done && w_last_idx;
      // Only one sweep may be queued; a trigger during a pending or running sweep is dropped.
      r_pending    <= scan_en && (w_start_scan ? 1'b0 : (r_pending || (w_trig && !r_active)));
      if (w_start) r_cur_wr <= w_start_wr;
      if (w_start_scan) r_active <= 1'b1;
      if (w_scan_done) begin
        r_idx <= w_last_idx ? 3'd0 : r_idx + 3'd1;
        if (w_last_idx) begin
          r_active <= 1'b0;
          r_sec    <= r_shadow[0];
          r_min    <= r_shadow[1];
          r_hour   <= r_shadow[2];
          r_day    <= r_shadow[3];
          r_month  <= r_shadow[4];
          r_year   <= w_rdata;
        end else begin
          r_shadow[r_idx] <= w_rdata;
        end
      end
    end
  end

  assign wr_ack       = w_done && r_cur_wr;
  assign busy         = w_busy;
  assign time_valid   = r_time_valid;
  assign scan_overrun = r_overrun;
  assign sec          = r_sec;
  assign min          = r_min;
  assign hour         = r_hour;
  assign day          = r_day;
  assign month        = r_month;
  assign year         = r_year;
endmodule
